multicycle_sequencer: RTL
=========================

Name: multicycle_sequencer

Overview:
- Multi-cycle execution controller that consumes the decoded control bundle (regwrite, memtoreg, memread, memwrite, branch, aluop, alusrc) and sequences each instruction through FETCH/DECODE/EXECUTE/MEM/WB.
- Issues per-phase datapath enables and memory requests with ready handshakes.
- Sits between the opcode decoder and the shared single-ALU, single-memory-port datapath.
- Counts retired instructions and traps memory hangs with a timeout.

Parameters:
- WAIT_LIMIT, 16: max consecutive cycles a memory request may wait for ready; must be >= 1.
- CNT_W, 32: width of the retired-instruction counter.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- run  in  1  allow a new fetch to start
- regwrite  in  1  decoded control, sampled in DECODE
- memtoreg  in  1  decoded control, sampled in DECODE
- memread  in  1  decoded control, sampled in DECODE
- memwrite  in  1  decoded control, sampled in DECODE
- branch  in  1  decoded control, sampled in DECODE
- aluop  in  2  decoded control, sampled in DECODE
- alusrc  in  1  decoded control, sampled in DECODE
- imem_ready  in  1  instruction memory ready/data valid
- dmem_ready  in  1  data memory ready/data valid
- imem_req  out  1  instruction fetch request
- ir_write  out  1  load instruction register
- pc_write  out  1  PC <= PC+4
- pc_write_cond  out  1  branch PC update, gated by datapath zero flag
- alu_op  out  2  ALU control class
- alu_src_b  out  1  ALU operand B select (1 = immediate)
- dmem_req  out  1  data memory request
- dmem_we  out  1  data memory write enable
- reg_we  out  1  register file write enable
- wb_sel  out  1  writeback select (1 = memory data)
- retire  out  1  one-cycle pulse when an instruction completes
- retire_count  out  CNT_W  retired-instruction count
- state_o  out  3  current state encoding
- error  out  1  sticky timeout flag

Behaviour:
- Clock and reset: one clock `clk`; reset `rst` is synchronous and active-high.
- State encoding: FETCH=0, DECODE=1, EXECUTE=2, MEM=3, WB=4, ERROR=5.
- Reset: state=FETCH; latched controls=0; wait counter=0; retire_count=0; error=0; all outputs 0.
- Outputs are Moore-style, decoded from the state register and latched controls. Exceptions: ir_write and pc_write also qualify on imem_ready.
- Defaults outside the listed states: all enables 0, alu_op=00, alu_src_b=0.
- FETCH, run=0: no request, stay, wait counter held at 0.
- FETCH, run=1: imem_req=1, alu_op=00.
  - imem_ready=1: ir_write=1 and pc_write=1 in the same cycle; next state DECODE.
  - imem_ready=0: stay.
- DECODE: register the full control bundle; next state EXECUTE. Inputs are ignored in all other states.
- EXECUTE: alu_op and alu_src_b driven from latched values.
  - branch=1: pc_write_cond=1, retire pulse, next FETCH.
  - memread or memwrite: next MEM.
  - regwrite: next WB.
  - none set (unknown opcode): treated as NOP; retire, next FETCH.
  - Priority: branch > memory > regwrite.
- MEM: dmem_req=1; dmem_we=latched memwrite; alu_src_b=1.
  - Stay until dmem_ready=1.
  - Then memread: next WB. Otherwise (store): retire, next FETCH.
  - memread and memwrite both set: executed as store plus WB (memwrite drives dmem_we; WB still occurs).
- WB: reg_we=latched regwrite; wb_sel=latched memtoreg; retire; next FETCH.
- Latency with ready in the first cycle: branch/NOP 3 cycles, R/I-type 4, store 4, load 5. Each ready-low cycle adds one.
- Wait counter:
  - Increments each cycle a request (imem_req or dmem_req) is high with its ready low.
  - Clears on ready, on state change, and in FETCH with run=0.
  - After WAIT_LIMIT consecutive ready-low cycles, the next state is ERROR.
  - A ready arriving on the WAIT_LIMIT-th cycle itself is accepted normally.
- ERROR: all enables and requests 0; error=1; state_o=5; exit only via rst.
- run dropping mid-instruction: the instruction still completes; only the next fetch is blocked.
- retire_count: increments on each retire and wraps modulo 2^CNT_W.
- rst asserted in any state, including mid-wait or ERROR: next cycle fully reset, no retire pulse.

Test Plan:
- R-type (regwrite=1, aluop=10, alusrc=0), readys always 1, run=1 → states 0,1,2,4; reg_we=1 with wb_sel=0 in cycle 4; retire once; retire_count=1.
- Load (regwrite, memtoreg, memread, alusrc=1), dmem_ready low 3 cycles → MEM held 4 cycles with dmem_req=1, dmem_we=0; WB with wb_sel=1; total 8 cycles.
- Store then branch back-to-back → store: dmem_we=1, retire at MEM exit, no WB. Branch: pc_write_cond=1 and alu_op=01 in EXECUTE, 3 cycles. retire_count=2.
- WAIT_LIMIT=4, imem_ready held 0 → ERROR entered after 4 low cycles; error=1; outputs 0. Ready arriving later is ignored. rst returns to FETCH with error=0.
- All-zero control bundle → FETCH→DECODE→EXECUTE→FETCH; retire pulse; no reg_we, dmem_req, or pc_write_cond.
- CNT_W=2, five NOPs → retire_count 1,2,3,0,1. Separately: rst asserted in MEM mid-wait → next state FETCH, no retire.

Source files
------------

// File: rtl/multicycle_sequencer.sv
// multicycle_sequencer: FETCH/DECODE/EXECUTE/MEM/WB controller with ready handshakes,
// retire counting and a memory-hang timeout that parks the machine in ERROR until reset.
module multicycle_sequencer #(
   parameter int WAIT_LIMIT = 16,
   parameter int CNT_W      = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             run,
   input  logic             regwrite,
   input  logic             memtoreg,
   input  logic             memread,
   input  logic             memwrite,
   input  logic             branch,
   input  logic [1:0]       aluop,
   input  logic             alusrc,
   input  logic             imem_ready,
   input  logic             dmem_ready,
   output logic             imem_req,
   output logic             ir_write,
   output logic             pc_write,
   output logic             pc_write_cond,
   output logic [1:0]       alu_op,
   output logic             alu_src_b,
   output logic             dmem_req,
   output logic             dmem_we,
   output logic             reg_we,
   output logic             wb_sel,
   output logic             retire,
   output logic [CNT_W-1:0] retire_count,
   output logic [2:0]       state_o,
   output logic             error
);
   typedef enum logic [2:0] {FETCH = 3'd0, DECODE = 3'd1, EXECUTE = 3'd2, MEM = 3'd3, WB = 3'd4, ERROR = 3'd5} state_t;
   typedef struct packed {
      logic       regwrite;
      logic       memtoreg;
      logic       memread;
      logic       memwrite;
      logic       branch;
      logic [1:0] aluop;
      logic       alusrc;
   } ctrl_t;
   localparam int WW = $clog2(WAIT_LIMIT + 1);
   state_t           state_q, state_d;
   ctrl_t            ctrl_q, ctrl_d;
   logic [WW-1:0]    wait_q, wait_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             error_q, error_d;
   logic             stall;
   always_comb begin
      state_d       = state_q;
      ctrl_d        = ctrl_q;
      imem_req      = 1'b0;
      ir_write      = 1'b0;
      pc_write      = 1'b0;
      pc_write_cond = 1'b0;
      alu_op        = 2'b00;
      alu_src_b     = 1'b0;
      dmem_req      = 1'b0;
      dmem_we       = 1'b0;
      reg_we        = 1'b0;
      wb_sel        = 1'b0;
      retire        = 1'b0;
      case (state_q)
         FETCH: if (run) begin
            imem_req = 1'b1;
            if (imem_ready) begin
               ir_write = 1'b1;
               pc_write = 1'b1;
               state_d  = DECODE;
            end
         end
         DECODE: begin
            ctrl_d  = '{regwrite, memtoreg, memread, memwrite, branch, aluop, alusrc};
            state_d = EXECUTE;
         end
         EXECUTE: begin
            alu_op    = ctrl_q.aluop;
            alu_src_b = ctrl_q.alusrc;
            if (ctrl_q.branch) begin
               pc_write_cond = 1'b1;
               retire        = 1'b1;
               state_d       = FETCH;
            end else if (ctrl_q.memread || ctrl_q.memwrite) state_d = MEM;
            else if (ctrl_q.regwrite) state_d = WB;
            else begin
               retire  = 1'b1;
               state_d = FETCH;
            end
         end
         MEM: begin
            dmem_req  = 1'b1;
            dmem_we   = ctrl_q.memwrite;
            alu_src_b = 1'b1;
            if (dmem_ready) begin
               retire  = !ctrl_q.memread;
               state_d = ctrl_q.memread ? WB : FETCH;
            end
         end
         WB: begin
            reg_we  = ctrl_q.regwrite;
            wb_sel  = ctrl_q.memtoreg;
            retire  = 1'b1;
            state_d = FETCH;
         end
         default: ;
      endcase
      // a stall always holds the state, so the counter only needs clearing when no stall
      stall  = (imem_req && !imem_ready) || (dmem_req && !dmem_ready);
      wait_d = stall ? wait_q + 1'b1 : '0;
      if (stall && wait_q == WW'(WAIT_LIMIT - 1)) state_d = ERROR;
      error_d = error_q || state_d == ERROR;
      cnt_d   = cnt_q + CNT_W'(retire);
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= FETCH;
         ctrl_q  <= '0;
         wait_q  <= '0;
         cnt_q   <= '0;
         error_q <= 1'b0;
      end else begin
         state_q <= state_d;
         ctrl_q  <= ctrl_d;
         wait_q  <= wait_d;
         cnt_q   <= cnt_d;
         error_q <= error_d;
      end
   end
   assign retire_count = cnt_q;
   assign state_o      = state_q;
   assign error        = error_q;
endmodule
